// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one combinational shifter between N_REQ ALU lanes.
// Round-robin grant feeds a two-stage pipe: the issue register drives the
// shifter, the result register captures its outputs for the consumer.
// Optional build macro SHIFT_ARB_PRIO0_EN: requester 0 wins whenever it is
// valid and its grant leaves the round-robin pointer untouched.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high; valid must not depend on ready, and
// the arbiter's req_ready is a combinational function of req_valid and the
// pipe occupancy.
module shift_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [3*N_REQ-1:0]    req_op,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [32*N_REQ-1:0]   req_c,
    input  logic [32*N_REQ-1:0]   req_d,
    output logic                  sh_shift_add,
    output logic                  sh_asr,
    output logic                  sh_left,
    output logic [31:0]           sh_a,
    output logic [31:0]           sh_b,
    output logic [31:0]           sh_c,
    output logic [31:0]           sh_d,
    input  logic [31:0]           sh_y1,
    input  logic [31:0]           sh_y2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_y1,
    output logic [31:0]           rsp_y2,
    output logic                  busy
);

    // Issue stage
    logic            iv_q, iv_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [ID_W-1:0] iid_q, iid_d;

    // Result stage
    logic            rv_q, rv_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     y1_q, y1_d, y2_q, y2_d;

    // Round-robin pointer: search for the next grant starts here
    logic [ID_W-1:0] rr_q, rr_d;

    logic            adv_r, adv_i, accept;
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   idx;

    assign adv_r  = !rv_q || rsp_ready;
    assign adv_i  = !iv_q || adv_r;
    // Gated by rst_n so no grant is visible while reset is asserted
    assign accept = rst_n && adv_i && grant_found;

    // Find the first valid requester at or after the pointer, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_REQ)) begin
                idx = idx - (ID_W+1)'(N_REQ);
            end
            if (!grant_found && req_valid[idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = idx[ID_W-1:0];
            end
        end
`ifdef SHIFT_ARB_PRIO0_EN
        if (req_valid[0]) begin
            grant_found = 1'b1;
            grant_idx   = '0;
        end
`endif
    end

    // One-hot accept towards the winning requester
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next state of issue stage, result stage and pointer
    always_comb begin
        iv_d  = iv_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        d_d   = d_q;
        iid_d = iid_q;
        rv_d  = rv_q;
        rid_d = rid_q;
        y1_d  = y1_q;
        y2_d  = y2_q;
        rr_d  = rr_q;

        if (accept) begin
            iv_d  = 1'b1;
            op_d  = req_op[3*int'(grant_idx) +: 3];
            a_d   = req_a[32*int'(grant_idx) +: 32];
            b_d   = req_b[32*int'(grant_idx) +: 32];
            c_d   = req_c[32*int'(grant_idx) +: 32];
            d_d   = req_d[32*int'(grant_idx) +: 32];
            iid_d = grant_idx;
            rr_d  = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
`ifdef SHIFT_ARB_PRIO0_EN
            if (grant_idx == '0) begin
                rr_d = rr_q;
            end
`endif
        end else if (adv_i) begin
            // Operands are held so the shifter inputs stay at the last issue
            iv_d = 1'b0;
        end

        if (adv_r) begin
            rv_d = iv_q;
            if (iv_q) begin
                rid_d = iid_q;
                y1_d  = sh_y1;
                y2_d  = sh_y2;
            end
        end
    end

    // Pipeline registers; reset discards any in-flight work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iv_q  <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            iid_q <= '0;
            rv_q  <= 1'b0;
            rid_q <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            rr_q  <= '0;
        end else begin
            iv_q  <= iv_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            d_q   <= d_d;
            iid_q <= iid_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
            y1_q  <= y1_d;
            y2_q  <= y2_d;
            rr_q  <= rr_d;
        end
    end

    // op encoding is {shift_add, asr, left}
    assign sh_shift_add = op_q[2];
    assign sh_asr       = op_q[1];
    assign sh_left      = op_q[0];
    assign sh_a         = a_q;
    assign sh_b         = b_q;
    assign sh_c         = c_q;
    assign sh_d         = d_q;

    assign rsp_valid = rv_q;
    assign rsp_id    = rid_q;
    assign rsp_y1    = y1_q;
    assign rsp_y2    = y2_q;
    assign busy      = iv_q || rv_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a small behavioural shifter.
// Shifter model: amount = shift_add ? (B+C)[4:0] : C[4:0];
//   y1 = A shifted (left / arithmetic right / logical right),
//   y2 = D shifted left when left, else logical right.
module tb_shift_arbiter;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [11:0]   req_op;
  logic [127:0]  req_a, req_b, req_c, req_d;
  logic          sh_shift_add, sh_asr, sh_left;
  logic [31:0]   sh_a, sh_b, sh_c, sh_d;
  logic [31:0]   sh_y1, sh_y2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_y1, rsp_y2;
  logic          busy;

  int n_cmp;
  int n_err;

  logic [31:0] sum_bc;
  logic [4:0]  amt;

  logic [31:0] rr_y1 [4] = '{32'h1, 32'h4, 32'hC, 32'h20};
  logic [31:0] rr_y2 [4] = '{32'h100, 32'h400, 32'hC00, 32'h2000};

  shift_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .sh_shift_add(sh_shift_add), .sh_asr(sh_asr), .sh_left(sh_left),
    .sh_a(sh_a), .sh_b(sh_b), .sh_c(sh_c), .sh_d(sh_d),
    .sh_y1(sh_y1), .sh_y2(sh_y2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y1(rsp_y1), .rsp_y2(rsp_y2), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // behavioural shifter
  always_comb begin
    sum_bc = sh_b + sh_c;
    amt    = sh_shift_add ? sum_bc[4:0] : sh_c[4:0];
    if (sh_left) sh_y1 = sh_a << amt;
    else if (sh_asr) sh_y1 = 32'($signed(sh_a) >>> amt);
    else sh_y1 = sh_a >> amt;
    sh_y2 = sh_left ? (sh_d << amt) : (sh_d >> amt);
  end

  // driver tasks
  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    req_op[3*i +: 3]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_c[32*i +: 32] = c;
    req_d[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 32'hA5A5_0000 + i, 32'h1, 32'h2, 32'h3);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_cmp++; if (rsp_y1 !== 32'h0 || rsp_y2 !== 32'h0) begin n_err++; $display("FAIL reset_rsp_y: got %h/%h want 0/0", rsp_y1, rsp_y2); end
    n_cmp++; if ({sh_shift_add, sh_asr, sh_left} !== 3'b000 || sh_a !== 32'h0 || sh_d !== 32'h0) begin n_err++; $display("FAIL reset_sh: got op %b a %h d %h want 0", {sh_shift_add, sh_asr, sh_left}, sh_a, sh_d); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    set_req(0, 3'b001, 32'h1, 32'h0, 32'h4, 32'h0);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL basic_grant: got %b want 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    @(negedge clk); #1;
    n_cmp++; if (sh_left !== 1'b1 || sh_a !== 32'h1 || sh_c !== 32'h4) begin n_err++; $display("FAIL basic_issue: got left %b a %h c %h want 1/1/4", sh_left, sh_a, sh_c); end
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL basic_t1: got rsp_valid %b busy %b want 0/1", rsp_valid, busy); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_err++; $display("FAIL basic_t2_valid: got %b id %0d want 1 id 0", rsp_valid, rsp_id); end
    n_cmp++; if (rsp_y1 !== 32'h10 || rsp_y2 !== 32'h0) begin n_err++; $display("FAIL basic_t2_y: got %h/%h want 10/0", rsp_y1, rsp_y2); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_drain: got rsp_valid %b busy %b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'b001, 32'(i + 1), 32'h0, 32'(i), 32'h100 * 32'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back({30'(k % 4), 2'(k % 4)});
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k < 5) begin
        n_cmp++; if (req_ready !== 4'b0001 << (k % 4)) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      end else if (k == 5) begin
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rr_idle_grant: got %b want 0000", req_ready); end
      end
      if (k >= 2 && k <= 6) begin
        e = exp_q.pop_front();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== e[1:0]) begin n_err++; $display("FAIL rr_rsp_id[%0d]: got v%b id %0d want v1 id %0d", k, rsp_valid, rsp_id, e[1:0]); end
        n_cmp++; if (rsp_y1 !== rr_y1[e[1:0]] || rsp_y2 !== rr_y2[e[1:0]]) begin n_err++; $display("FAIL rr_rsp_y[%0d]: got %h/%h want %h/%h", k, rsp_y1, rsp_y2, rr_y1[e[1:0]], rr_y2[e[1:0]]); end
      end
      if (k == 7) begin
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_end_valid: got %b want 0", rsp_valid); end
      end
      step();
      if (k == 4) req_valid = 4'b0000;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(1, 3'b000, 32'hF000_0000, 32'h0, 32'h4, 32'h1234);
    set_req(2, 3'b010, 32'h8000_0000, 32'h0, 32'h8, 32'hFF00);
    set_req(3, 3'b001, 32'h3, 32'h0, 32'd30, 32'h1);
    req_valid = 4'b1110;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL stall_grant1: got %b want 0010", req_ready); end
    step(); req_valid = 4'b1100;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL stall_grant2: got %b want 0100", req_ready); end
    step(); req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_no_grant[%0d]: got %b want 0000", k, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y1 !== 32'h0F00_0000 || rsp_y2 !== 32'h123) begin n_err++; $display("FAIL stall_hold_rsp[%0d]: got v%b id %0d %h/%h want v1 id 1 0f000000/123", k, rsp_valid, rsp_id, rsp_y1, rsp_y2); end
      n_cmp++; if (sh_a !== 32'h8000_0000 || sh_asr !== 1'b1) begin n_err++; $display("FAIL stall_hold_sh[%0d]: got a %h asr %b want 80000000/1", k, sh_a, sh_asr); end
      if (k < 2) step();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL stall_release_grant: got %b want 1000", req_ready); end
    step(); req_valid = 4'b0000;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_y1 !== 32'hFF80_0000 || rsp_y2 !== 32'hFF) begin n_err++; $display("FAIL stall_drain_2: got v%b id %0d %h/%h want v1 id 2 ff800000/ff", rsp_valid, rsp_id, rsp_y1, rsp_y2); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y1 !== 32'hC000_0000 || rsp_y2 !== 32'h4000_0000) begin n_err++; $display("FAIL stall_drain_3: got v%b id %0d %h/%h want v1 id 3 c0000000/40000000", rsp_valid, rsp_id, rsp_y1, rsp_y2); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall_empty: got v%b busy %b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_shift_add();
    do_reset();
    set_req(0, 3'b100, 32'h8000_0000, 32'd30, 32'd1, 32'h0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    step(); req_valid = 4'b0000;
    @(negedge clk); #1;
    n_cmp++; if (sh_shift_add !== 1'b1 || sh_b !== 32'd30 || sh_c !== 32'd1) begin n_err++; $display("FAIL sadd_issue: got sa %b b %0d c %0d want 1/30/1", sh_shift_add, sh_b, sh_c); end
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_y1 !== 32'h1 || rsp_y2 !== 32'h0) begin n_err++; $display("FAIL sadd_result: got v%b %h/%h want v1 1/0", rsp_valid, rsp_y1, rsp_y2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 3'b001, 32'h1, 32'h0, 32'h2, 32'h7);
    set_req(1, 3'b000, 32'h55, 32'h0, 32'h1, 32'h9);
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    step(); req_valid = 4'b0010;
    step(); req_valid = 4'b0000;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b1 || busy !== 1'b1 || sh_a !== 32'h55) begin n_err++; $display("FAIL midrst_full: got v%b busy %b a %h want 1/1/55", rsp_valid, busy, sh_a); end
    req_valid = 4'b0011;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL midrst_now: got v%b busy %b rdy %b want 0/0/0000", rsp_valid, busy, req_ready); end
    n_cmp++; if (sh_a !== 32'h0 || sh_d !== 32'h0 || sh_left !== 1'b0 || rsp_y1 !== 32'h0 || rsp_id !== 2'd0) begin n_err++; $display("FAIL midrst_clear: got a %h d %h left %b y1 %h id %0d want zeros", sh_a, sh_d, sh_left, rsp_y1, rsp_id); end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_no_rsp[%0d]: got v%b busy %b want 0/0", k, rsp_valid, busy); end
    end
  endtask

  task automatic test_prio0();
    logic [3:0] exp_g [3];
`ifdef SHIFT_ARB_PRIO0_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0100, 4'b0001};
`endif
    do_reset();
    set_req(0, 3'b001, 32'h1, 32'h0, 32'h1, 32'h0);
    set_req(1, 3'b001, 32'h3, 32'h0, 32'h1, 32'h0);
    set_req(2, 3'b001, 32'h2, 32'h0, 32'h2, 32'h0);
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (req_ready !== exp_g[k]) begin n_err++; $display("FAIL prio_grant[%0d]: got %b want %b", k, req_ready, exp_g[k]); end
      if (k == 2) begin
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_y1 !== 32'h2) begin n_err++; $display("FAIL prio_first_rsp: got v%b id %0d y1 %h want v1 id 0 y1 2", rsp_valid, rsp_id, rsp_y1); end
      end
      step();
      @(negedge clk);
    end
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL prio_rr_after: got %b want 0010", req_ready); end
    step(); req_valid = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    req_d     = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_shift_add();
    test_reset_mid();
    test_prio0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
